// File: rtl/cdr_ctrl_pkg.sv
// cdr_ctrl_pkg: FSM states, DLF gain codes and helpers shared by the CDR acquisition controller.
package cdr_ctrl_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        ACQ    = 3'd2,
        TRACK  = 3'd3,
        LOCKED = 3'd4
    } cdr_state_t;

    localparam int KP_ACQ = 8;
    localparam int KI_ACQ = 4;
    localparam int KP_TRK = 2;
    localparam int KI_TRK = 1;

    function automatic int net_abs(input int n);
        return (n < 0) ? -n : n;
    endfunction
endpackage

// File: rtl/cdr_win_acc.sv
// cdr_win_acc: per-window cycle counter and signed BBPD up/dn vote accumulator.
module cdr_win_acc #(
    parameter int WIN_LEN = 256,
    parameter int NW      = $clog2(WIN_LEN) + 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 up,
    input  logic                 dn,
    output logic                 win_done,
    output logic signed [NW-1:0] net
);
    localparam int CW = $clog2(WIN_LEN);

    logic [CW-1:0]        cnt;
    logic signed [NW-1:0] acc;
    logic signed [NW-1:0] vote;

    // net already includes the current cycle's vote, so win_done sees all WIN_LEN samples
    assign vote     = (up & ~dn) ? NW'(1) : (dn & ~up) ? '1 : '0;
    assign net      = acc + vote;
    assign win_done = ~clr & (&cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            acc <= '0;
        end else if (clr) begin
            cnt <= '0;
            acc <= '0;
        end else begin
            cnt <= cnt + 1'b1;
            acc <= win_done ? '0 : net;
        end
    end
endmodule

// File: rtl/cdr_acq_controller.sv
// cdr_acq_controller: CDR acquisition sequencer selecting DLF gains/hold and reporting lock.
// Optional relock statistics counter enabled by defining CDR_CTRL_STATS_EN.
module cdr_acq_controller
    import cdr_ctrl_pkg::*;
#(
    parameter int WIN_LEN    = 256,
    parameter int SETTLE_CYC = 32,
    parameter int LOCK_THR   = 16,
    parameter int UNLOCK_THR = 64,
    parameter int LOCK_WINS  = 4,
    parameter int GAIN_W     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              up,
    input  logic              dn,
    output logic [GAIN_W-1:0] kp_sel,
    output logic [GAIN_W-1:0] ki_sel,
    output logic              dlf_hold,
    output logic              lock,
    output logic [2:0]        state_o
`ifdef CDR_CTRL_STATS_EN
    ,
    output logic [7:0]        relock_cnt
`endif
);
    localparam int NW = $clog2(WIN_LEN) + 2;
    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int GW = $clog2(LOCK_WINS + 1);

    cdr_state_t           state, nxt;
    logic [SW-1:0]        settle_cnt;
    logic [GW-1:0]        good_cnt, good_nxt;
    logic                 clr, win_done, good, bad;
    logic signed [NW-1:0] net;
    int                   net_mag;

    assign clr     = ~en | ~(state inside {ACQ, TRACK, LOCKED});
    assign net_mag = net_abs(int'(net));
    assign good    = net_mag <= LOCK_THR;
    assign bad     = net_mag > UNLOCK_THR;
    assign state_o = state;

    cdr_win_acc #(.WIN_LEN(WIN_LEN), .NW(NW)) u_win (
        .clk(clk), .rst_n(rst_n), .clr(clr), .up(up), .dn(dn),
        .win_done(win_done), .net(net)
    );

    always_comb begin
        nxt      = state;
        good_nxt = good_cnt;
        if (!en) begin
            nxt      = IDLE;
            good_nxt = '0;
        end else begin
            case (state)
                IDLE:   nxt = SETTLE;
                SETTLE: nxt = (settle_cnt == SW'(SETTLE_CYC - 1)) ? ACQ : SETTLE;
                ACQ: if (win_done) begin
                    good_nxt = good ? good_cnt + 1'b1 : '0;
                    if (good && good_cnt == GW'(LOCK_WINS - 1)) begin
                        nxt      = TRACK;
                        good_nxt = '0;
                    end
                end
                TRACK:  if (win_done) nxt = good ? LOCKED : bad ? ACQ : TRACK;
                LOCKED: if (win_done && bad) nxt = ACQ;
                default: nxt = IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they register alongside it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            good_cnt   <= '0;
            kp_sel     <= GAIN_W'(KP_ACQ);
            ki_sel     <= GAIN_W'(KI_ACQ);
            dlf_hold   <= 1'b1;
            lock       <= 1'b0;
        end else begin
            state      <= nxt;
            settle_cnt <= (state == SETTLE && nxt == SETTLE) ? settle_cnt + 1'b1 : '0;
            good_cnt   <= good_nxt;
            kp_sel     <= (nxt inside {TRACK, LOCKED}) ? GAIN_W'(KP_TRK) : GAIN_W'(KP_ACQ);
            ki_sel     <= (nxt inside {TRACK, LOCKED}) ? GAIN_W'(KI_TRK) : GAIN_W'(KI_ACQ);
            dlf_hold   <= nxt inside {IDLE, SETTLE};
            lock       <= nxt == LOCKED;
        end
    end

`ifdef CDR_CTRL_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            relock_cnt <= '0;
        else if (state == LOCKED && nxt == ACQ && relock_cnt != 8'hFF)
            relock_cnt <= relock_cnt + 8'd1;
    end
`endif
endmodule

// File: tb/tb_cdr_acq_controller.sv
// tb_cdr_acq_controller: randomized scoreboard bench for cdr_acq_controller against a window-level model.
module tb_cdr_acq_controller;
    localparam int WIN_LEN    = 256;
    localparam int SETTLE_CYC = 32;
    localparam int LOCK_THR   = 16;
    localparam int UNLOCK_THR = 64;
    localparam int LOCK_WINS  = 4;
    localparam int S_IDLE = 0, S_SETTLE = 1, S_ACQ = 2, S_TRACK = 3, S_LOCKED = 4;

    logic       clk = 1'b0;
    logic       rst_n, en, up, dn;
    logic [3:0] kp_sel, ki_sel;
    logic       dlf_hold, lock;
    logic [2:0] state_o;
    logic [7:0] relock_cnt;

    always #5 clk = ~clk;

    cdr_acq_controller #(
        .WIN_LEN(WIN_LEN), .SETTLE_CYC(SETTLE_CYC), .LOCK_THR(LOCK_THR),
        .UNLOCK_THR(UNLOCK_THR), .LOCK_WINS(LOCK_WINS), .GAIN_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .dn(dn),
        .kp_sel(kp_sel), .ki_sel(ki_sel), .dlf_hold(dlf_hold), .lock(lock),
        .state_o(state_o)
`ifdef CDR_CTRL_STATS_EN
        , .relock_cnt(relock_cnt)
`endif
    );
`ifndef CDR_CTRL_STATS_EN
    assign relock_cnt = 8'd0;
`endif

    // Reference model: mode, samples seen in the current window and their vote sum
    int ms, settled, pos, sum, goods, relocks;
    int n_tests = 0, n_fail = 0;
    logic [20:0] exp_q[$];

    function automatic logic [20:0] expv();
        logic [7:0] rc;
`ifdef CDR_CTRL_STATS_EN
        rc = 8'(relocks);
`else
        rc = 8'd0;
`endif
        return {3'(ms), (ms >= S_TRACK) ? 4'd2 : 4'd8, (ms >= S_TRACK) ? 4'd1 : 4'd4,
                ms <= S_SETTLE, ms == S_LOCKED, rc};
    endfunction

    task automatic model_clear();
        ms = S_IDLE; settled = 0; pos = 0; sum = 0; goods = 0;
    endtask

    task automatic model_edge(input logic e, input logic u, input logic d);
        int mag;
        if (!e) begin
            model_clear();
        end else if (ms == S_IDLE) begin
            ms = S_SETTLE; settled = 0;
        end else if (ms == S_SETTLE) begin
            settled++;
            if (settled == SETTLE_CYC) begin
                ms = S_ACQ; pos = 0; sum = 0;
            end
        end else begin
            sum += int'(u) - int'(d);
            pos++;
            if (pos == WIN_LEN) begin
                mag = (sum < 0) ? -sum : sum;
                pos = 0; sum = 0;
                if (ms == S_ACQ) begin
                    goods = (mag <= LOCK_THR) ? goods + 1 : 0;
                    if (goods == LOCK_WINS) begin
                        ms = S_TRACK; goods = 0;
                    end
                end else if (ms == S_TRACK) begin
                    ms = (mag <= LOCK_THR) ? S_LOCKED : (mag > UNLOCK_THR) ? S_ACQ : S_TRACK;
                end else if (mag > UNLOCK_THR) begin
                    ms = S_ACQ;
                    if (relocks < 255) relocks++;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic e, input logic u, input logic d);
        @(negedge clk);
        rst_n = r; en = e; up = u; dn = d;
        if (!r) begin
            model_clear(); relocks = 0;
        end else begin
            model_edge(e, u, d);
        end
        exp_q.push_back(expv());
    endtask

    task automatic settle();
        repeat (SETTLE_CYC + 1) step(1, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    // fill: 0 = idle cycles, 1 = up&dn cycles, 2 = random mix of both
    task automatic win(input int net, input int fill, input bit drop_en_last = 0);
        int k, off;
        logic e, b;
        k   = (net < 0) ? -net : net;
        off = int'($urandom_range(0, WIN_LEN - k));
        for (int i = 0; i < WIN_LEN; i++) begin
            e = !(drop_en_last && i == WIN_LEN - 1);
            b = (fill == 2) ? 1'($urandom_range(0, 1)) : (fill == 1);
            if (i >= off && i < off + k) step(1, e, net > 0, net < 0);
            else step(1, e, b, b);
        end
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        model_clear(); relocks = 0;
        exp_q.push_back(expv());
        rst_n = 1'b0;
    endtask

    initial begin : monitor
        logic [20:0] e;
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if ({state_o, kp_sel, ki_sel, dlf_hold, lock, relock_cnt} !== e) begin
                    n_fail++;
                    $display("FAIL outputs t=%0t got st=%0d kp=%0d ki=%0d hold=%b lock=%b rc=%0d exp st=%0d kp=%0d ki=%0d hold=%b lock=%b rc=%0d",
                             $time, state_o, kp_sel, ki_sel, dlf_hold, lock, relock_cnt,
                             e[20:18], e[17:14], e[13:10], e[9], e[8], e[7:0]);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        rst_n = 1'b0; en = 1'b0; up = 1'b0; dn = 1'b0;
        model_clear(); relocks = 0;
        repeat (3) step(0, 0, 0, 0);
        repeat (2) step(1, 0, 0, 0);
        // quiet lines: settle, four good windows to TRACK, one more to LOCKED
        settle();
        repeat (5) win(0, 0);
        // full-window up drives loss of lock
        win(256, 0);
        // bad window after three good restarts the count
        repeat (3) win(10, 2);
        win(20, 2);
        repeat (4) win(10, 2);
        win(40, 2);
        win(-70, 2);
        // both asserted every cycle still nets zero
        repeat (5) win(0, 1);
        repeat (8) win(int'($urandom_range(0, 200)) - 100, 2);
        // en dropped on the 4th good window's final cycle
        step(1, 0, 0, 0);
        settle();
        repeat (3) win(-12, 2);
        win(16, 2, 1);
        repeat (3) step(1, 0, 0, 0);
        // async reset mid-window while locked
        settle();
        repeat (5) win(5, 2);
        repeat (100) step(1, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        async_reset();
        repeat (2) step(0, 1, 0, 0);
        repeat (2) step(1, 0, 0, 0);
        settle();
        repeat (2) win(0, 0);
        repeat (2) @(posedge clk);
        #3;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
